// File: rtl/mdu_sequencer_if.sv
// mdu_sequencer_if: E/D-stage signal bundle for the multiply/divide sequencer.
//   master: pipeline side (drives E-stage operands/control and D-stage MDU flag,
//           observes HI/LO, busy and the D-stage stall request).
//   slave : the MDU itself.
interface mdu_sequencer_if;
   logic        E_start;        // E-stage instruction is mult/multu/div/divu
   logic [2:0]  E_MDUOp;        // NOP=0 MULT=1 MULTU=2 DIV=3 DIVU=4 MTHI=5 MTLO=6
   logic [31:0] E_A;            // forwarded rs
   logic [31:0] E_B;            // forwarded rt
   logic        D_MDU_related;  // D-stage instruction touches HI/LO or the MDU
   logic [31:0] hi_out;
   logic [31:0] lo_out;
   logic        busy;
   logic        stall_md;

   modport master (
      output E_start, E_MDUOp, E_A, E_B, D_MDU_related,
      input  hi_out, lo_out, busy, stall_md
   );

   modport slave (
      input  E_start, E_MDUOp, E_A, E_B, D_MDU_related,
      output hi_out, lo_out, busy, stall_md
   );
endinterface

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle multiply/divide unit for the E stage.
// Holds HI/LO, computes the 64-bit mult/div result at start, then counts down a busy period
// and commits the result to HI/LO on the final busy edge. Raises stall_md for any D-stage
// MDU instruction while an operation is starting or in flight.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high
//   bus   - mdu_sequencer_if.slave (E-stage controls/operands, D flag, HI/LO, busy, stall_md)
module mdu_sequencer #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input logic             clk,
   input logic             reset,
   mdu_sequencer_if.slave  bus
);

   localparam logic [2:0] OpMult  = 3'd1;
   localparam logic [2:0] OpMultu = 3'd2;
   localparam logic [2:0] OpDiv   = 3'd3;
   localparam logic [2:0] OpDivu  = 3'd4;
   localparam logic [2:0] OpMthi  = 3'd5;
   localparam logic [2:0] OpMtlo  = 3'd6;

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] res_hi_q, res_hi_d;
   logic [31:0] res_lo_q, res_lo_d;
   logic        busy_q, busy_d;

   // Operand datapath, evaluated every cycle but only captured on a start.
   logic        is_mul, is_div, op_signed;
   logic [63:0] mul_a, mul_b, prod;
   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag, div_n, div_d, q_raw, r_raw, quot, rem;

   assign is_mul    = (bus.E_MDUOp == OpMult) || (bus.E_MDUOp == OpMultu);
   assign is_div    = (bus.E_MDUOp == OpDiv)  || (bus.E_MDUOp == OpDivu);
   assign op_signed = (bus.E_MDUOp == OpMult) || (bus.E_MDUOp == OpDiv);

   // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then correct for both.
   assign mul_a = op_signed ? {{32{bus.E_A[31]}}, bus.E_A} : {32'd0, bus.E_A};
   assign mul_b = op_signed ? {{32{bus.E_B[31]}}, bus.E_B} : {32'd0, bus.E_B};
   assign prod  = mul_a * mul_b;

   // Signed divide is done on magnitudes with one shared unsigned divider, then sign-fixed:
   // quotient truncates toward zero, remainder takes the dividend's sign. This also keeps
   // 0x80000000 / -1 well defined (quotient 0x80000000, remainder 0).
   assign a_neg = op_signed & bus.E_A[31];
   assign b_neg = op_signed & bus.E_B[31];
   assign a_mag = a_neg ? (32'd0 - bus.E_A) : bus.E_A;
   assign b_mag = b_neg ? (32'd0 - bus.E_B) : bus.E_B;
   assign div_n = a_mag;
   assign div_d = (b_mag == 32'd0) ? 32'd1 : b_mag;
   assign q_raw = div_n / div_d;
   assign r_raw = div_n % div_d;
   assign quot  = (a_neg ^ b_neg) ? (32'd0 - q_raw) : q_raw;
   assign rem   = a_neg ? (32'd0 - r_raw) : r_raw;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      res_hi_d = res_hi_q;
      res_lo_d = res_lo_q;
      busy_d   = busy_q;
      unique case (state_q)
         StIdle: begin
            if (bus.E_start && (is_mul || is_div)) begin
               if (is_mul) begin
                  res_hi_d = prod[63:32];
                  res_lo_d = prod[31:0];
                  cnt_d    = 4'(MULT_CYCLES);
               end else begin
                  // Divide by zero commits the current HI/LO, i.e. leaves them unchanged.
                  res_hi_d = (bus.E_B == 32'd0) ? hi_q : rem;
                  res_lo_d = (bus.E_B == 32'd0) ? lo_q : quot;
                  cnt_d    = 4'(DIV_CYCLES);
               end
               state_d = StRun;
               busy_d  = 1'b1;
            end else if (bus.E_MDUOp == OpMthi) begin
               hi_d = bus.E_A;
            end else if (bus.E_MDUOp == OpMtlo) begin
               lo_d = bus.E_A;
            end
         end
         StRun: begin
            // Starts and MTHI/MTLO are ignored here so the in-flight op is never disturbed.
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               hi_d    = res_hi_q;
               lo_d    = res_lo_q;
               state_d = StIdle;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = 4'd0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         cnt_q    <= 4'd0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         res_hi_q <= 32'd0;
         res_lo_q <= 32'd0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         res_hi_q <= res_hi_d;
         res_lo_q <= res_lo_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.hi_out   = hi_q;
   assign bus.lo_out   = lo_q;
   assign bus.busy     = busy_q;
   // E_start term covers the start cycle itself, before busy rises.
   assign bus.stall_md = bus.D_MDU_related & (bus.E_start | busy_q);

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed plus randomized stimulus for mdu_sequencer. A per-cycle reference
// model computes expected HI/LO/busy/stall from plain 64-bit arithmetic and a remaining-busy
// counter; the driver pushes expectations into a scoreboard queue and a separate negedge monitor
// pops and compares.
module tb_mdu_sequencer;

   localparam int unsigned MC = 5;
   localparam int unsigned DC = 10;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mdu_sequencer_if bus ();

   mdu_sequencer #(
      .MULT_CYCLES (MC),
      .DIV_CYCLES  (DC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        busy;
      logic        stall;
      int          cyc;
   } exp_t;

   exp_t sbq[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   // Reference model state (values visible in the current cycle).
   logic [31:0] m_hi, m_lo, m_phi, m_plo;
   int          m_left  = 0;
   bit          m_valid = 1'b0;

   task automatic check(input string name, input int c, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual=%h expected=%h", name, c, act, exp);
      end
   endtask

   task automatic model_compute(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      int sa, sb;
      longint p, q, r;
      longint unsigned pu, qu, ru;
      sa = a;
      sb = b;
      case (op)
         3'd1: begin
            p = longint'(sa) * longint'(sb);
            m_phi = p[63:32]; m_plo = p[31:0];
         end
         3'd2: begin
            pu = {32'd0, a} * {32'd0, b};
            m_phi = pu[63:32]; m_plo = pu[31:0];
         end
         3'd3: begin
            if (b == 32'd0) begin
               m_phi = m_hi; m_plo = m_lo;
            end else begin
               q = longint'(sa) / longint'(sb);
               r = longint'(sa) % longint'(sb);
               m_phi = r[31:0]; m_plo = q[31:0];
            end
         end
         default: begin
            if (b == 32'd0) begin
               m_phi = m_hi; m_plo = m_lo;
            end else begin
               qu = {32'd0, a} / {32'd0, b};
               ru = {32'd0, a} % {32'd0, b};
               m_phi = ru[31:0]; m_plo = qu[31:0];
            end
         end
      endcase
   endtask

   // One clock cycle: drive inputs, record expected outputs for this cycle, advance the model.
   task automatic step(input logic rst, input logic st, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic d);
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      reset             = rst;
      bus.E_start       = st;
      bus.E_MDUOp       = op;
      bus.E_A           = a;
      bus.E_B           = b;
      bus.D_MDU_related = d;
      if (m_valid) begin
         e.hi    = m_hi;
         e.lo    = m_lo;
         e.busy  = (m_left > 0);
         e.stall = d & (st | (m_left > 0));
         e.cyc   = cyc;
         sbq.push_back(e);
      end
      if (rst) begin
         m_hi = 32'd0; m_lo = 32'd0; m_left = 0; m_valid = 1'b1;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            m_hi = m_phi; m_lo = m_plo;
         end
      end else if (st && op >= 3'd1 && op <= 3'd4) begin
         model_compute(op, a, b);
         m_left = (op <= 3'd2) ? MC : DC;
      end else if (op == 3'd5) begin
         m_hi = a;
      end else if (op == 3'd6) begin
         m_lo = a;
      end
   endtask

   task automatic idle(input int n, input logic d);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, d);
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic d);
      step(1'b0, (op >= 3'd1 && op <= 3'd4), op, a, b, d);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         check("hi_out", e.cyc, bus.hi_out, e.hi);
         check("lo_out", e.cyc, bus.lo_out, e.lo);
         check("busy", e.cyc, {31'd0, bus.busy}, {31'd0, e.busy});
         check("stall_md", e.cyc, {31'd0, bus.stall_md}, {31'd0, e.stall});
      end
   end

   initial begin
      logic [2:0]  op;
      logic [31:0] a, b;
      reset = 1'b1;
      bus.E_start = 1'b0; bus.E_MDUOp = 3'd0; bus.E_A = 32'd0; bus.E_B = 32'd0;
      bus.D_MDU_related = 1'b0;
      step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
      idle(2, 1'b1);

      issue(3'd1, 32'hFFFF_FFFD, 32'd5, 1'b0);          // MULT -3*5
      idle(7, 1'b0);
      issue(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);          // MULTU
      idle(7, 1'b0);
      issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);          // DIV -7/2, stall window held
      idle(11, 1'b1);
      idle(1, 1'b0);
      issue(3'd5, 32'h11, 32'd0, 1'b0);
      issue(3'd6, 32'h22, 32'd0, 1'b0);
      issue(3'd4, 32'd7, 32'd0, 1'b0);                  // DIVU by zero, stall never raised
      idle(12, 1'b0);
      issue(3'd5, 32'hDEAD_BEEF, 32'd0, 1'b1);          // MTHI/MTLO: no busy, no stall
      issue(3'd6, 32'h1234_5678, 32'd0, 1'b1);
      idle(2, 1'b1);
      issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);  // signed overflow case
      idle(11, 1'b0);
      issue(3'd1, 32'h0000_1234, 32'h0000_5678, 1'b1);  // reset at busy cycle 3
      idle(2, 1'b1);
      step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
      idle(6, 1'b1);
      issue(3'd2, 32'd3, 32'd4, 1'b0);                  // back-to-back starts
      idle(5, 1'b0);
      issue(3'd4, 32'd100, 32'd7, 1'b1);
      idle(11, 1'b0);

      for (int i = 0; i < 600; i++) begin
         op = 3'($urandom_range(0, 6));
         a  = $urandom();
         b  = ($urandom_range(0, 7) == 0) ? 32'd0 :
              ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 9)) : $urandom();
         if ($urandom_range(0, 3) == 0) b = 32'd0 - b;
         if ($urandom_range(0, 149) == 0)
            step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'($urandom_range(0, 1)));
         else
            issue(op, a, b, 1'($urandom_range(0, 1)));
      end
      idle(12, 1'b0);

      @(negedge clk);
      @(negedge clk);
      n_tests++;
      if (sbq.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain actual=%0d expected=0", sbq.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
